// File: rtl/cpu_player_pkg.sv
// Shared types and constants for the computer-opponent key generator.
package cpu_player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned LFSR_W = 10;
  // Zero-based tap positions for x^10 + x^7 + 1
  localparam int unsigned TAP_HI = 9;
  localparam int unsigned TAP_LO = 6;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 10'h001;

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR; loads seed while reset is low.
module lfsr10
  import cpu_player_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= seed;
    end else begin
      q <= {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
    end
  end

endmodule

// File: rtl/cpu_player.sv
// Computer-opponent key generator: fixed-length presses separated by a release
// gap, started by fire or by an LFSR draw scaled by speed.
module cpu_player
  import cpu_player_pkg::*;
#(
  parameter int unsigned       HOLD_CYCLES = 4,
  parameter int unsigned       GAP_CYCLES  = 8,
  parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] speed,
  input  logic       fire,
  output logic       key,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  // An all-zero seed would lock the LFSR up
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? DEFAULT_SEED : SEED;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             key_nx, pressed_nx;
  logic [7:0]       count_nx;
  logic [LFSR_W-1:0] lfsr_q;
  logic             trig_c;
  logic             lfsr_unused_c;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED_EFF),
    .q     (lfsr_q)
  );

  // Top three LFSR bits form a uniform 0..7 draw compared against speed
  assign trig_c        = enable & (fire | (lfsr_q[LFSR_W-1 -: 3] < speed));
  assign lfsr_unused_c = ^lfsr_q[LFSR_W-4:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      key         <= 1'b0;
      pressed     <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      key         <= key_nx;
      pressed     <= pressed_nx;
      press_count <= count_nx;
    end
  end

  // Once a press starts, HOLD and GAP run to completion regardless of inputs
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pressed_nx = 1'b0;
    count_nx   = press_count;
    case (state)
      IDLE: begin
        if (trig_c) begin
          state_nx   = HOLD;
          cnt_nx     = HOLD_LOAD;
          pressed_nx = 1'b1;
          count_nx   = press_count + 8'd1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LOAD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    key_nx = (state_nx == HOLD);
  end

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: per-cycle scoreboard against a
// press-timer model plus directed checks on press shape, gating and wrap.
module tb_cpu_player;

  localparam int HOLD = 4;
  localparam int GAP  = 8;
  localparam logic [9:0] SEED = 10'h001;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic       fire   = 1'b0;
  logic [2:0] speed  = 3'd0;
  logic       key;
  logic       pressed;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] sb[$];

  // Model: a single countdown covering the whole press (hold + gap)
  logic [9:0] m_lfsr;
  int         m_rem;
  logic       m_key;
  logic       m_pressed;
  logic [7:0] m_count;

  int   obs_rise, obs_high, obs_press, cyc, last_rise, period;
  logic prev_key;

  cpu_player dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .speed       (speed),
    .fire        (fire),
    .key         (key),
    .pressed     (pressed),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr    = SEED;
    m_rem     = 0;
    m_key     = 1'b0;
    m_pressed = 1'b0;
    m_count   = 8'd0;
  endtask

  task automatic clear_obs();
    obs_rise  = 0;
    obs_high  = 0;
    obs_press = 0;
    last_rise = -1;
    period    = 0;
  endtask

  // Predict the next edge, push expectation, clock, then pop and compare
  task automatic tick();
    logic       trig;
    logic [9:0] e;
    if (!reset) begin
      model_reset();
    end else begin
      trig = enable && (fire || (m_lfsr[9:7] < speed));
      m_pressed = 1'b0;
      if (m_rem == 0) begin
        if (trig) begin
          m_rem     = HOLD + GAP;
          m_pressed = 1'b1;
          m_count   = m_count + 8'd1;
        end
      end else begin
        m_rem = m_rem - 1;
      end
      m_key  = (m_rem > GAP);
      m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
    sb.push_back({m_key, m_pressed, m_count});
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("sb_key", 32'(key), 32'(e[9]));
    check("sb_pressed", 32'(pressed), 32'(e[8]));
    check("sb_count", 32'(press_count), 32'(e[7:0]));
    if (key === 1'b1 && prev_key !== 1'b1) begin
      obs_rise++;
      if (last_rise >= 0) period = cyc - last_rise;
      last_rise = cyc;
    end
    if (key === 1'b1) obs_high++;
    if (pressed === 1'b1) obs_press++;
    prev_key = key;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cyc = 0;
    prev_key = 1'b0;
    model_reset();
    clear_obs();

    // Reset held with fire asserted
    reset = 1'b0; enable = 1'b1; fire = 1'b1; speed = 3'd7;
    ticks(3);
    check("reset_key", 32'(key), 0);
    check("reset_pressed", 32'(pressed), 0);
    check("reset_count", 32'(press_count), 0);

    // Single one-cycle fire at speed 0
    reset = 1'b1; fire = 1'b0; speed = 3'd0;
    ticks(2);
    clear_obs();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    check("fire_key", 32'(key), 1);
    check("fire_pressed", 32'(pressed), 1);
    check("fire_count", 32'(press_count), 1);
    ticks(109);
    check("single_rise", 32'(obs_rise), 1);
    check("single_high", 32'(obs_high), 4);
    check("single_press", 32'(obs_press), 1);
    check("single_count", 32'(press_count), 1);

    // Asynchronous reset in the middle of HOLD
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
    check("midhold_key", 32'(key), 1);
    reset = 1'b0;
    #1;
    check("async_key", 32'(key), 0);
    check("async_count", 32'(press_count), 0);
    model_reset();
    prev_key = 1'b0;
    ticks(2);
    reset = 1'b1;

    // Fire held: back-to-back presses at the minimum period
    clear_obs();
    fire = 1'b1;
    ticks(39);
    fire = 1'b0;
    check("held_rise", 32'(obs_rise), 3);
    check("held_high", 32'(obs_high), 12);
    check("held_count", 32'(press_count), 3);
    check("held_period", 32'(period), 13);
    ticks(12);

    // Enable gating
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    enable = 1'b0; fire = 1'b1; speed = 3'd7;
    clear_obs();
    ticks(50);
    check("gate_rise", 32'(obs_rise), 0);
    check("gate_count", 32'(press_count), 0);
    enable = 1'b1;
    ticks(2);
    enable = 1'b0;
    ticks(20);
    check("gate_one_rise", 32'(obs_rise), 1);
    check("gate_one_high", 32'(obs_high), 4);
    check("gate_one_count", 32'(press_count), 1);
    fire = 1'b0;

    // Random presses at speed 7
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    enable = 1'b1; fire = 1'b0; speed = 3'd7;
    ticks(1023);
    check("rand7_count", 32'(press_count), 32'(m_count));

    // Speed 0 never presses on its own
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    speed = 3'd0;
    clear_obs();
    ticks(1023);
    check("rand0_count", 32'(press_count), 0);
    check("rand0_rise", 32'(obs_rise), 0);

    // 256 presses wrap the press counter
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
    fire = 1'b1; speed = 3'd0;
    clear_obs();
    ticks(1 + 255 * 13);
    fire = 1'b0;
    check("wrap_count", 32'(press_count), 0);
    check("wrap_pressed", 32'(pressed), 1);
    check("wrap_rise", 32'(obs_rise), 256);
    ticks(12);
    check("wrap_high", 32'(obs_high), 256 * HOLD);
    check("wrap_key", 32'(key), 0);
    check("wrap_period", 32'(period), HOLD + GAP + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_player.md
# cpu_player

Computer-opponent key generator for the tug-of-war game. Produces a physical-key-like level waveform: clean presses of fixed length separated by a guaranteed release gap. Its output feeds the same press conditioner a human KEY feeds, so it drives the conditioner's input rather than reading it. Press timing is pseudo-random from an internal LFSR, scaled by a 3-bit difficulty setting. A `fire` input forces deterministic presses for test and demo.

## Interface
Parameters:
- HOLD_CYCLES, 4: cycles `key` stays high per press; must be ≥1.
- GAP_CYCLES, 8: cycles `key` stays low after a press before a new press can be decided; must be ≥1.
- SEED, 10'h001: LFSR reset value; 0 is illegal and is replaced by 10'h001.

Ports:
- clk  input  1  system clock.
- reset  input  1  one clock; reset is asynchronous and active-low (0 = in reset).
- enable  input  1  permits new presses from IDLE.
- speed  input  3  difficulty; a press starts with probability speed/8 per IDLE cycle.
- fire  input  1  forces a press from IDLE when enable=1, regardless of speed.
- key  output  1  registered key level, high while pressed.
- pressed  output  1  one-cycle pulse in the first HOLD cycle.
- press_count  output  8  number of presses started, wraps 255→0.

## Operation
- LFSR: 10-bit Fibonacci, polynomial x^10+x^7+1; shifts every cycle, including during reset release and when enable=0; never reaches 0.
- Trigger: `trig = enable & (fire | (lfsr[9:7] < speed))`. speed=0 gives no random presses; speed=7 gives 7/8.
- FSM states:
  - IDLE: if `trig`, go to HOLD and load the counter with HOLD_CYCLES-1; otherwise stay.
  - HOLD: `key`=1. Counter decrements; at 0, go to GAP and load GAP_CYCLES-1.
  - GAP: `key`=0. At 0, go to IDLE.
- Press integrity: once HOLD is entered, HOLD and GAP always run to completion. Deasserting `enable`, or changing `speed`/`fire`, mid-press has no effect until IDLE.
- `pressed` and the `press_count` increment occur on the IDLE→HOLD transition.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1).

## Timing
- Reset values, applied immediately and asynchronously: state=IDLE, key=0, pressed=0, press_count=0, lfsr=SEED, counter=0.
- Reset mid-HOLD: `key` drops with `reset` low, without waiting for a clock edge.
- If `trig` is sampled at edge k, then `key` and `pressed` are high after edge k. `key` is high for exactly HOLD_CYCLES cycles and falls after edge k+HOLD_CYCLES.
- IDLE is re-entered after edge k+HOLD_CYCLES+GAP_CYCLES. The earliest next rise is after edge k+HOLD_CYCLES+GAP_CYCLES+1, so the minimum rise-to-rise period is HOLD+GAP+1 cycles (13 with defaults).
- All outputs are registered; there is no combinational path from inputs to outputs.
- `fire`/`enable` high for one cycle in IDLE is sufficient to start a press. Held high, they give back-to-back presses at the minimum period.

## Structure
- Package `cpu_player_pkg`: state typedef (IDLE, HOLD, GAP), LFSR width constant 10, tap positions (9, 6), default SEED.
- Sub-module `lfsr10`: ports clk, reset, seed, q[9:0]; free-running, same reset semantics as the parent.
- Top level contains the FSM, counter, output registers and press counter.

## Test plan
- Reset: hold reset=0 with fire=1 → key=0, pressed=0, press_count=0. Drive reset=0 mid-HOLD → key falls with no clock edge.
- Single fire, speed=0: 1-cycle fire → key high 4 cycles, low; pressed one pulse; press_count=1; no further press over 100 cycles.
- Fire held high, speed=0, 40 cycles → key rises every 13 cycles (3 full presses), press_count=3.
- Enable gating: enable=0, fire=1, speed=7 for 50 cycles → key never rises. Then enable=1 for 2 cycles, then 0 → exactly one complete 4-cycle press.
- Random mode: SEED=1, speed=7, fire=0, 1023 cycles → key/press_count match a cycle-accurate reference model of the LFSR and FSM. Same run with speed=0 → press_count=0.
- Wrap: fire held for 256 presses → press_count reads 0 after the 256th press; key still 4 high / 8 low.
